// File: rtl/seg_scan_display.sv
// Six-digit multiplexed 7-segment driver for a {hour, min, sec} binary time bus.
// The bus is sampled once per scan frame so a displayed frame never mixes two time values.
module seg_scan_display #(
  parameter int unsigned SCAN_DIV = 50_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] data_in,
  output logic [5:0]  sel,
  output logic [7:0]  seg
);

  localparam int unsigned DIV_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned LAST_IDX   = NUM_DIGITS - 1;

  typedef struct packed {
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
  } time_t;

  logic [DIV_W-1:0] div_cnt;
  logic [IDX_W-1:0] idx;
  time_t            snap;

  logic             tick_c;
  logic             frame_wrap_c;
  logic [7:0]       byte_c;
  logic [3:0]       tens_c;
  logic [3:0]       ones_c;
  logic [3:0]       digit_c;
  logic             dash_c;
  logic [5:0]       sel_c;
  logic [7:0]       seg_c;

  // Active-low segment pattern {g,f,e,d,c,b,a} for a decimal digit.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] code;
    code = 7'h7F;
    case (d)
      4'd0: code = 7'h40;
      4'd1: code = 7'h79;
      4'd2: code = 7'h24;
      4'd3: code = 7'h30;
      4'd4: code = 7'h19;
      4'd5: code = 7'h12;
      4'd6: code = 7'h02;
      4'd7: code = 7'h78;
      4'd8: code = 7'h00;
      4'd9: code = 7'h10;
      default: code = 7'h7F;
    endcase
    return code;
  endfunction

  assign tick_c       = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign frame_wrap_c = tick_c && (idx == IDX_W'(LAST_IDX));

  // Digit-slot divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick_c) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Slot index advances once per tick and wraps after the hour-tens slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (tick_c) begin
      idx <= frame_wrap_c ? '0 : idx + IDX_W'(1);
    end
  end

  // Time snapshot, refreshed only at the frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap <= '0;
    end else if (frame_wrap_c) begin
      snap <= time_t'(data_in);
    end
  end

  // Slot decode: choose the byte, split into decimal digits, map to segments.
  always_comb begin
    byte_c  = snap.hour;
    tens_c  = '0;
    ones_c  = '0;
    digit_c = '0;
    dash_c  = 1'b0;
    sel_c   = 6'h3F;
    seg_c   = 8'hFF;

    case (idx)
      IDX_W'(0), IDX_W'(1): byte_c = snap.sec;
      IDX_W'(2), IDX_W'(3): byte_c = snap.min;
      default:              byte_c = snap.hour;
    endcase

    dash_c  = (byte_c > 8'd99);
    tens_c  = 4'(byte_c / 8'd10);
    ones_c  = 4'(byte_c % 8'd10);
    digit_c = idx[0] ? tens_c : ones_c;

    seg_c[6:0] = dash_c ? 7'b0111111 : seg_code(digit_c);
    seg_c[7]   = !((idx == IDX_W'(2)) || (idx == IDX_W'(4)));
    sel_c      = ~(6'b000001 << idx);
  end

  // Select and segments update together on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel <= 6'h3F;
      seg <= 8'hFF;
    end else begin
      sel <= sel_c;
      seg <= seg_c;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display: stimulus queues expected slot outputs,
// a monitor pops one entry each time the digit select moves and checks dwell and one-hot.
module tb_seg_scan_display;

  localparam int unsigned SCAN_DIV = 4;

  logic        clk;
  logic        rst;
  logic [23:0] data_in;
  logic [5:0]  sel;
  logic [7:0]  seg;

  int total = 0;
  int bad   = 0;

  logic [13:0] exp_q[$];

  seg_scan_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .sel     (sel),
    .seg     (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Reference seven-segment patterns, bit 7 is the decimal point (1 = off).
  function automatic logic [7:0] ref_seg(input logic [7:0] b, input int slot);
    logic [6:0] tbl [10];
    logic [6:0] code;
    int v;
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    v = int'(b);
    if (v >= 100) code = 7'h3F;
    else if (slot % 2 == 1) code = tbl[v / 10];
    else code = tbl[v % 10];
    return {(slot == 2 || slot == 4) ? 1'b0 : 1'b1, code};
  endfunction

  function automatic logic [47:0] model_frame(input logic [23:0] t);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      case (i / 2)
        0: r[i*8 +: 8] = ref_seg(t[7:0], i);
        1: r[i*8 +: 8] = ref_seg(t[15:8], i);
        default: r[i*8 +: 8] = ref_seg(t[23:16], i);
      endcase
    end
    return r;
  endfunction

  // segs holds slot 0 in bits [7:0] up to slot 5 in bits [47:40].
  task automatic push_frame(input logic [47:0] segs);
    logic [5:0] s;
    for (int i = 0; i < 6; i++) begin
      s = ~(6'b000001 << i);
      exp_q.push_back({s, segs[i*8 +: 8]});
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Monitor: one pop per slot change, plus dwell and one-hot-low checks.
  initial begin
    logic [5:0]  prev_sel;
    logic        first;
    int          dwell;
    logic [13:0] e;
    prev_sel = 6'h3F;
    first    = 1'b1;
    dwell    = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_sel = 6'h3F;
        first    = 1'b1;
        dwell    = 0;
      end else begin
        dwell++;
        if (sel !== prev_sel) begin
          if (!first) check("dwell", 32'(dwell), 32'(SCAN_DIV));
          dwell = 0;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL slot_unexpected: got sel=%b seg=%h want no new slot", sel, seg);
          end else begin
            e = exp_q.pop_front();
            check("slot_sel", 32'(sel), 32'(e[13:8]));
            check("slot_seg", 32'(seg), 32'(e[7:0]));
          end
          prev_sel = sel;
          first    = 1'b0;
        end
        if (!first) check("onehot", 32'($countones(~sel)), 32'd1);
      end
    end
  end

  initial begin
    logic [23:0] rnd;
    rst     = 1'b1;
    data_in = 24'h0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_sel", 32'(sel), 32'h3F);
    check("reset_seg", 32'(seg), 32'hFF);

    // Frame 0 shows zeros even though data_in already holds 23:59:59.
    data_in = 24'h173B3B;
    rst     = 1'b0;
    push_frame(48'hC040C040C0C0);
    push_frame(48'hA43092109290);

    // Mid-frame change at slot 2: current frame keeps 23:59:59.
    wait_edges(33);
    data_in = 24'h0C2238;
    push_frame(48'hF924B0199282);

    // Seconds byte 200 dashes both seconds digits only.
    wait_edges(17);
    data_in = 24'h0C22C8;
    push_frame(48'hF924B019BFBF);

    // Asynchronous reset in the middle of slot 3.
    wait_edges(36);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_sel", 32'(sel), 32'h3F);
    check("async_rst_seg", 32'(seg), 32'hFF);
    exp_q.delete();
    wait_edges(2);
    rst = 1'b0;
    push_frame(48'hC040C040C0C0);

    // Random frames, with the 99/100 boundary first.
    for (int f = 0; f < 100; f++) begin
      rnd = (f == 0) ? 24'h636400 : 24'($urandom);
      data_in = rnd;
      push_frame(model_frame(rnd));
      wait_edges(24);
    end

    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
